// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the requester-side and memory-side buses of mem_arbiter.
//   master : arbiter view (samples requests and memory responses, drives grants and memory requests)
//   slave  : environment view (requesters plus the external memory)
interface mem_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_we;
   logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
   logic [NUM_REQ*DATA_BITS-1:0] req_wdata;
   logic [NUM_REQ-1:0]           req_ready;
   logic [DATA_BITS-1:0]         rsp_rdata;
   logic                         mem_valid;
   logic                         mem_we;
   logic [ADDR_BITS-1:0]         mem_addr;
   logic [DATA_BITS-1:0]         mem_wdata;
   logic                         mem_ready;
   logic [DATA_BITS-1:0]         mem_rdata;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
      output req_ready, rsp_rdata, mem_valid, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
      input  req_ready, rsp_rdata, mem_valid, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port among NUM_REQ requesters.
// One transaction in flight; the grant stays locked until the memory handshake
// completes, then the granted requester gets a one-cycle req_ready pulse.
// Optional feature macro: MEM_ARB_PERF_EN adds saturating transaction/stall counters.
module mem_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.master bus
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [15:0]   perf_txn_count,
   output logic [15:0]   perf_stall_count
`endif
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

   state_t               state_q;
   logic [IDX_W-1:0]     ptr_q;
   logic [IDX_W-1:0]     grant_q;
   logic                 mem_valid_q;
   logic                 mem_we_q;
   logic [ADDR_BITS-1:0] mem_addr_q;
   logic [DATA_BITS-1:0] mem_wdata_q;
   logic [DATA_BITS-1:0] rdata_q;
   logic [NUM_REQ-1:0]   req_ready_q;

   // Per-requester views of the packed address/data buses
   logic [ADDR_BITS-1:0] addr_arr  [NUM_REQ];
   logic [DATA_BITS-1:0] wdata_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = bus.req_addr[gi*ADDR_BITS +: ADDR_BITS];
         assign wdata_arr[gi] = bus.req_wdata[gi*DATA_BITS +: DATA_BITS];
      end
   endgenerate

   // Round-robin pick: first pending request scanning ptr, ptr+1, ... (lowest offset wins)
   logic             arb_hit;
   logic [IDX_W-1:0] arb_idx;
   logic [IDX_W-1:0] scan_sel;

   always_comb begin
      arb_hit  = 1'b0;
      arb_idx  = '0;
      scan_sel = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         scan_sel = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
         if (bus.req_valid[scan_sel]) begin
            arb_hit = 1'b1;
            arb_idx = scan_sel;
         end
      end
   end

   // Transaction FSM; every output is a register so the buses stay glitch-free
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         req_ready_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               req_ready_q <= '0;
               if (arb_hit) begin
                  grant_q     <= arb_idx;
                  mem_valid_q <= 1'b1;
                  mem_we_q    <= bus.req_we[arb_idx];
                  mem_addr_q  <= addr_arr[arb_idx];
                  mem_wdata_q <= wdata_arr[arb_idx];
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.mem_ready) begin
                  mem_valid_q <= 1'b0;
                  // writes leave the last read data visible on rsp_rdata
                  if (!mem_we_q) begin
                     rdata_q <= bus.mem_rdata;
                  end
                  req_ready_q <= NUM_REQ'(1) << grant_q;
                  state_q     <= RESPOND;
               end
            end
            RESPOND: begin
               req_ready_q <= '0;
               ptr_q       <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.req_ready = req_ready_q;
   assign bus.rsp_rdata = rdata_q;

`ifdef MEM_ARB_PERF_EN
   logic [15:0] txn_cnt_q;
   logic [15:0] stall_cnt_q;

   // Saturating counters of completed transactions and memory wait cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         txn_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (state_q == RESPOND && txn_cnt_q != 16'hFFFF) begin
            txn_cnt_q <= txn_cnt_q + 16'd1;
         end
         if (state_q == ISSUE && !bus.mem_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign perf_txn_count   = txn_cnt_q;
   assign perf_stall_count = stall_cnt_q;
`endif
endmodule
